// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_if
//  Purpose  : Word handshake and serial-side signals of the UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;
    logic                 tx;
    logic                 busy;

    modport master (output in_valid, in_data, input in_ready, tx, busy);
    modport slave  (input in_valid, in_data, output in_ready, tx, busy);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter: start, LSB-first data, optional parity, stops.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_tx_if.slave  bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] c_BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic              c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic              c_ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               r_state,  w_state_n;
    logic [BAUD_W-1:0]    r_baud,   w_baud_n;
    logic [BIT_W-1:0]     r_bit,    w_bit_n;
    logic                 r_stop,   w_stop_n;
    logic [DATA_BITS-1:0] r_shreg,  w_shreg_n;
    logic                 r_parity, w_parity_n;
    logic                 r_tx,     w_tx_n;
    logic                 r_busy,   w_busy_n;
    logic                 r_ready,  w_ready_n;
    logic                 w_wrap;

    assign w_wrap = (r_baud == c_BAUD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_stop   <= 1'b0;
            r_shreg  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_baud   <= w_baud_n;
            r_bit    <= w_bit_n;
            r_stop   <= w_stop_n;
            r_shreg  <= w_shreg_n;
            r_parity <= w_parity_n;
            r_tx     <= w_tx_n;
            r_busy   <= w_busy_n;
            r_ready  <= w_ready_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_baud_n   = r_baud;
        w_bit_n    = r_bit;
        w_stop_n   = r_stop;
        w_shreg_n  = r_shreg;
        w_parity_n = r_parity;
        w_tx_n     = r_tx;
        w_busy_n   = r_busy;
        w_ready_n  = r_ready;

        // The baud counter free-runs through every bit slot; slots advance on wrap.
        if (r_state != IDLE) begin
            w_baud_n = w_wrap ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (bus.in_valid && r_ready) begin
                    w_shreg_n  = bus.in_data;
                    w_parity_n = (^bus.in_data) ^ c_ODD;
                    w_state_n  = START;
                    w_baud_n   = '0;
                    w_tx_n     = 1'b0;
                    w_busy_n   = 1'b1;
                    w_ready_n  = 1'b0;
                end
            end
            START: begin
                if (w_wrap) begin
                    w_state_n = DATA;
                    w_bit_n   = '0;
                    w_tx_n    = r_shreg[0];
                    w_shreg_n = r_shreg >> 1;
                end
            end
            DATA: begin
                if (w_wrap) begin
                    if (r_bit == c_LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            w_state_n = PARITY;
                            w_tx_n    = r_parity;
                        end else begin
                            w_state_n = STOP;
                            w_stop_n  = 1'b0;
                            w_tx_n    = 1'b1;
                        end
                    end else begin
                        w_bit_n   = r_bit + 1'b1;
                        w_tx_n    = r_shreg[0];
                        w_shreg_n = r_shreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_wrap) begin
                    w_state_n = STOP;
                    w_stop_n  = 1'b0;
                    w_tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (w_wrap) begin
                    if (r_stop == c_STOP_LAST) begin
                        w_state_n = IDLE;
                        w_busy_n  = 1'b0;
                        w_ready_n = 1'b1;
                    end else begin
                        w_stop_n = r_stop + 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_tx_n    = 1'b1;
                w_busy_n  = 1'b0;
                w_ready_n = 1'b1;
            end
        endcase
    end

    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.in_ready = r_ready;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed frame-table bench for uart_tx (8N1, 8E1, 8O1 at 4 clk/bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;
    localparam int C  = 4;
    localparam int NV = 10;

    logic       clk = 1'b0;
    logic       clk_en;
    logic       rst;
    logic [2:0] v;
    logic [7:0] d;
    int         checks = 0;
    int         errors = 0;

    uart_tx_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_if #(.DATA_BITS(8)) bus2 ();

    assign bus0.in_valid = v[0];
    assign bus1.in_valid = v[1];
    assign bus2.in_valid = v[2];
    assign bus0.in_data  = d;
    assign bus1.in_data  = d;
    assign bus2.in_data  = d;

    wire logic [2:0] w_tx    = {bus2.tx,       bus1.tx,       bus0.tx};
    wire logic [2:0] w_busy  = {bus2.busy,     bus1.busy,     bus0.busy};
    wire logic [2:0] w_ready = {bus2.in_ready, bus1.in_ready, bus0.in_ready};

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [11:0] bits;   // bit j is the j-th bit on the line (start first)
        int         nbits;
        bit         hold;    // keep in_valid high and queue nxt
        logic [7:0] nxt;
        bit         disturb; // wiggle in_valid/in_data mid-frame
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_frame(input vec_t t);
        int f;
        f = t.nbits * C;
        d = t.data;
        v[t.sel] = 1'b1;
        @(posedge clk);
        #1;
        if (t.hold) d = t.nxt;
        else        v[t.sel] = 1'b0;
        for (int c = 0; c <= f; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c < f) begin
                chk($sformatf("tx d%0d %02h cyc%0d", t.sel, t.data, c), 32'(w_tx[t.sel]),
                    32'(t.bits[c / C]));
                chk($sformatf("busy d%0d cyc%0d", t.sel, c), 32'(w_busy[t.sel]), 32'd1);
                chk($sformatf("ready d%0d cyc%0d", t.sel, c), 32'(w_ready[t.sel]), 32'd0);
            end else begin
                chk($sformatf("end tx d%0d", t.sel), 32'(w_tx[t.sel]), 32'd1);
                chk($sformatf("end busy d%0d", t.sel), 32'(w_busy[t.sel]), 32'd0);
                chk($sformatf("end ready d%0d", t.sel), 32'(w_ready[t.sel]), 32'd1);
            end
            if (t.disturb && c == 10) begin
                d = 8'hFF;
                v[t.sel] = 1'b1;
            end
            if (t.disturb && c == 14) begin
                v[t.sel] = 1'b0;
                d = t.data;
            end
        end
        if (!t.hold) begin
            @(posedge clk);
            #1;
            chk($sformatf("post busy d%0d", t.sel), 32'(w_busy[t.sel]), 32'd0);
            chk($sformatf("post tx d%0d", t.sel), 32'(w_tx[t.sel]), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        vec_t t01;
        tbl[0] = '{0, 8'hA5, 12'h34A, 10, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{0, 8'h00, 12'h200, 10, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{0, 8'hFF, 12'h3FE, 10, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{0, 8'h3C, 12'h278, 10, 1'b1, 8'hC3, 1'b0};
        tbl[4] = '{0, 8'hC3, 12'h386, 10, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1, 8'hA5, 12'h54A, 11, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{1, 8'h07, 12'h60E, 11, 1'b0, 8'h00, 1'b0};
        tbl[7] = '{2, 8'hA5, 12'h74A, 11, 1'b0, 8'h00, 1'b0};
        tbl[8] = '{2, 8'h07, 12'h40E, 11, 1'b0, 8'h00, 1'b0};
        tbl[9] = '{0, 8'hA5, 12'h34A, 10, 1'b0, 8'h00, 1'b1};
        t01    = '{0, 8'h01, 12'h202, 10, 1'b0, 8'h00, 1'b0};

        clk_en = 1'b1;
        rst    = 1'b1;
        v      = 3'b000;
        d      = 8'h00;
        #1;
        chk("reset tx",    32'(w_tx),    32'h7);
        chk("reset ready", 32'(w_ready), 32'h7);
        chk("reset busy",  32'(w_busy),  32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_frame(tbl[i]);

        // Reset during data bit 3 of 0xA5 with the clock halted.
        @(negedge clk);
        d = 8'hA5;
        v[0] = 1'b1;
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        repeat (3 * C + 1 + C) @(posedge clk);
        #2;
        chk("pre-rst tx bit3",  32'(w_tx[0]),   32'd0);
        chk("pre-rst busy",     32'(w_busy[0]), 32'd1);
        clk_en = 1'b0;
        #10;
        rst = 1'b1;
        #1;
        chk("mid rst tx",    32'(w_tx[0]),    32'd1);
        chk("mid rst busy",  32'(w_busy[0]),  32'd0);
        chk("mid rst ready", 32'(w_ready[0]), 32'd1);
        #20;
        d = 8'h01;
        v[0] = 1'b1;
        rst = 1'b0;
        #3;
        clk_en = 1'b1;
        run_frame(t01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
